seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the datapath's combinational ALU.
- Covers the base ops plus XOR, shifts, compares, an iterative multiply and iterative unsigned divide/remainder.
- Sits between register-read and writeback. Downstream may stall it through a valid/ready output handshake.
- Single-cycle ops complete in 1 cycle. MUL/DIV/REM complete in XLEN+1 cycles.

Parameters:
- XLEN, 64, operand/result width; must be a power of 2, range 8..64.
- OP_W, 4, width of op code.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  XLEN  operand A.
- b  input  XLEN  operand B.
- op  input  OP_W  operation code.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.
- err  output  1  illegal/disabled op code.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA (shift amount = b[log2(XLEN)-1:0]).
  - 8 SLT (signed), 9 SLTU; both give 1 or 0, zero-extended.
  - 10 MUL (low XLEN bits of product), 11 DIVU, 12 REMU, 13 DIV, 14 REM.
  - 15 reserved.
- Arithmetic wraps modulo 2^XLEN. No carry or overflow outputs.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture a, b, op.
    - Single-cycle op or illegal op: go to DONE.
    - MUL/DIV-class op: go to BUSY, cnt=0.
  - BUSY: one iteration per cycle (shift-add multiply; restoring divide). cnt increments each cycle; after cnt reaches XLEN-1, go to DONE.
  - DONE: out_valid=1. result, zero and err are held stable. When out_ready=1, go to IDLE.
- Latency from the accept edge to the first cycle with out_valid high:
  - Single-cycle ops: 1 cycle.
  - Iterative ops: XLEN+1 cycles.
- in_ready=0 in BUSY and DONE. There is no overlap of requests; throughput is one request per (latency+1) cycles minimum.
- out_valid stays high until handshake completes. result must not change while out_valid=1 and out_ready=0.
- Divide-by-zero (b==0):
  - DIVU gives all ones; REMU gives a.
  - Handled in 1 cycle (direct to DONE); err=0.
- Illegal op (15, or disabled 13/14): result=0, zero=1, err=1, 1-cycle latency.
- zero is computed from the registered result.
- Reset (any time, including mid-BUSY):
  - State goes to IDLE; in-flight operation discarded.
  - Outputs: out_valid=0, result=0, zero=1, err=0, in_ready=1 on first cycle after rst_n deasserts.
- Inputs are sampled only at the accept edge. Changes to a/b/op afterwards have no effect.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_DIV_EN.
- Defined: op 13 DIV and op 14 REM are signed, truncating toward zero; remainder takes the dividend's sign. Implemented as magnitude divide with sign fix-up in the DONE transition, same XLEN+1 latency. Edge cases:
  - Divide-by-zero: DIV gives all ones; REM gives a.
  - Overflow (a = most negative, b = -1): DIV gives a; REM gives 0.
- Not defined: ops 13/14 are illegal (result=0, err=1, 1-cycle latency). No signed-divide logic is synthesised.

Test Plan:
- XLEN=64: ADD a=5, b=7 -> out_valid 1 cycle after accept, result=12, zero=0. SUB a=b=9 -> result=0, zero=1.
- SRA a=0x8000_0000_0000_0000, b=4 -> result=0xF800_0000_0000_0000. SLT a=-1, b=1 -> result=1. SLTU with the same operands -> result=0.
- MUL a=0xFFFF_FFFF, b=0xFFFF_FFFF -> out_valid exactly 65 cycles after accept; result=0xFFFF_FFFE_0000_0001. in_ready stays 0 throughout.
- DIVU a=100, b=7 -> 14. REMU with the same operands -> 2. DIVU b=0 -> all ones after 1 cycle. REMU b=0 -> a.
- Hold out_ready=0 for 10 cycles after MUL completes -> result stable, in_ready=0. Raise out_ready -> IDLE next cycle. A new ADD is accepted the following cycle.
- Assert rst_n=0 at cycle 20 of a DIVU -> out_valid=0, in_ready=1 after release. A new ADD 1+1 returns 2. With SEQ_ALU_SIGNED_DIV_EN: DIV -7/2 -> -3 and REM -7/2 -> -1. Without the macro: op 13 -> err=1, result=0.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops plus iterative MUL/DIVU/REMU.
// Define SEQ_ALU_SIGNED_DIV_EN to enable signed DIV (13) and REM (14).
module seq_alu #(
   parameter int XLEN = 64,
   parameter int OP_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [OP_W-1:0] op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            err
);

   localparam int SH = $clog2(XLEN);
   localparam logic [SH-1:0] LAST = SH'(XLEN - 1);

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SLL  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_DIVU = OP_W'(11);
   localparam logic [OP_W-1:0] OP_REMU = OP_W'(12);
   localparam logic [OP_W-1:0] OP_DIV  = OP_W'(13);
   localparam logic [OP_W-1:0] OP_REM  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_RSV  = OP_W'(15);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t state, nstate;

   logic [XLEN-1:0] acc_q, x_q, y_q, res_q;
   logic [XLEN-1:0] alu_res, acc_n, x_n, fin;
   logic [XLEN:0]   rem_sh, diff;
   logic [OP_W-1:0] op_q;
   logic [SH-1:0]   cnt;
   logic            err_q;
   logic            div_op, iter_op, illegal, dz;

`ifdef SEQ_ALU_SIGNED_DIV_EN
   logic            sgn_op, nq_q, nr_q;
   logic [XLEN-1:0] a_mag, b_mag;

   assign sgn_op = (op == OP_DIV) || (op == OP_REM);
   assign a_mag  = a[XLEN-1] ? -a : a;
   assign b_mag  = b[XLEN-1] ? -b : b;
`endif

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLL:  alu_res = a << b[SH-1:0];
         OP_SRL:  alu_res = a >> b[SH-1:0];
         OP_SRA:  alu_res = $signed(a) >>> b[SH-1:0];
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      div_op  = (op == OP_DIVU) || (op == OP_REMU);
      illegal = (op == OP_RSV);
`ifdef SEQ_ALU_SIGNED_DIV_EN
      div_op  = div_op || (op == OP_DIV) || (op == OP_REM);
`else
      illegal = illegal || (op == OP_DIV) || (op == OP_REM);
`endif
      dz      = div_op && (b == '0);
      iter_op = (op == OP_MUL) || (div_op && (b != '0));
   end

   // acc holds product (MUL) or partial remainder; x is multiplicand or quotient
   always_comb begin
      rem_sh = {acc_q, x_q[XLEN-1]};
      diff   = rem_sh - {1'b0, y_q};
      if (op_q == OP_MUL) begin
         acc_n = acc_q + (y_q[0] ? x_q : '0);
         x_n   = x_q << 1;
      end else if (!diff[XLEN]) begin
         acc_n = diff[XLEN-1:0];
         x_n   = {x_q[XLEN-2:0], 1'b1};
      end else begin
         acc_n = rem_sh[XLEN-1:0];
         x_n   = {x_q[XLEN-2:0], 1'b0};
      end
   end

   always_comb begin
      fin = acc_n;
      if (op_q == OP_DIVU) fin = x_n;
`ifdef SEQ_ALU_SIGNED_DIV_EN
      if (op_q == OP_DIV) fin = nq_q ? -x_n : x_n;
      if (op_q == OP_REM) fin = nr_q ? -acc_n : acc_n;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         res_q <= '0;
         op_q  <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
         nq_q  <= 1'b0;
         nr_q  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  cnt   <= '0;
                  err_q <= illegal;
                  unique case (1'b1)
                     illegal: res_q <= '0;
                     dz: res_q <= ((op == OP_REMU) || (op == OP_REM)) ? a : '1;
                     iter_op: begin
                        acc_q <= '0;
                        x_q   <= a;
                        y_q   <= b;
`ifdef SEQ_ALU_SIGNED_DIV_EN
                        if (sgn_op) begin
                           x_q <= a_mag;
                           y_q <= b_mag;
                        end
                        nq_q <= sgn_op && (a[XLEN-1] ^ b[XLEN-1]);
                        nr_q <= sgn_op && a[XLEN-1];
`endif
                     end
                     default: res_q <= alu_res;
                  endcase
               end
            end
            S_BUSY: begin
               acc_q <= acc_n;
               x_q   <= x_n;
               y_q   <= (op_q == OP_MUL) ? (y_q >> 1) : y_q;
               cnt   <= cnt + SH'(1);
               if (cnt == LAST) res_q <= fin;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE: if (in_valid) nstate = iter_op ? S_BUSY : S_DONE;
         S_BUSY: if (cnt == LAST) nstate = S_DONE;
         S_DONE: if (out_ready) nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      result    = res_q;
      zero      = (res_q == '0);
      err       = err_q;
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (XLEN=64): driver pushes model results,
// monitor pops and checks on every output handshake.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a, b;
   logic [3:0]  op;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;
   logic        zero;
   logic        err;

   seq_alu #(.XLEN(64), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        e;
      int          acc;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          pending = 0;
   bit          chk_idle = 0;
   int          stall_left = 0;
   int          hold_n = 0;
   logic [63:0] held;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model straight from the op table
   task automatic model(input logic [3:0] o, input logic [63:0] x,
                        input logic [63:0] y, output logic [63:0] r,
                        output logic e, output int lat);
      longint sx, sy;
      logic [127:0] p;
      sx = x;
      sy = y;
      r = 0;
      e = 0;
      lat = 1;
      case (o)
         0: r = x + y;
         1: r = x - y;
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: r = x << y[5:0];
         6: r = x >> y[5:0];
         7: r = sx >>> y[5:0];
         8: r = (sx < sy) ? 64'd1 : 64'd0;
         9: r = (x < y) ? 64'd1 : 64'd0;
         10: begin
            p = x * y;
            r = p[63:0];
            lat = 65;
         end
         11: begin
            r = (y == 0) ? '1 : x / y;
            lat = (y == 0) ? 1 : 65;
         end
         12: begin
            r = (y == 0) ? x : x % y;
            lat = (y == 0) ? 1 : 65;
         end
`ifdef SEQ_ALU_SIGNED_DIV_EN
         13, 14: begin
            lat = (y == 0) ? 1 : 65;
            if (y == 0) r = (o == 13) ? '1 : x;
            else if (x == 64'h8000_0000_0000_0000 && y == '1)
               r = (o == 13) ? x : 64'd0;
            else r = (o == 13) ? sx / sy : sx % sy;
         end
`endif
         default: e = 1;
      endcase
   endtask

   task automatic send(input logic [3:0] o, input logic [63:0] x,
                       input logic [63:0] y);
      exp_t t;
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 300);
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
         return;
      end
      op = o;
      a = x;
      b = y;
      in_valid = 1;
      @(posedge clk);
      #1;
      model(o, x, y, t.res, t.e, t.lat);
      t.acc = cyc;
      sb.push_back(t);
      in_valid = 0;
      op = 4'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
   endtask

   always @(negedge clk) begin
      exp_t t;
      if (!rst_n) begin
         pending = 0;
         chk_idle = 0;
         stall_left = 0;
         out_ready = 0;
      end else begin
         if (chk_idle) begin
            chk("idle_in_ready", in_ready, 1);
            chk_idle = 0;
         end
         if (out_valid) begin
            if (!pending) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", 1, 0);
               end else begin
                  t = sb.pop_front();
                  chk("result", result, t.res);
                  chk("zero", zero, t.res == 0);
                  chk("err", err, t.e);
                  chk("latency", cyc - t.acc + 1, t.lat);
               end
               held = result;
               pending = 1;
               if (hold_n > 0) stall_left = hold_n;
               else if ($urandom_range(0, 3) == 0)
                  stall_left = $urandom_range(1, 3);
               else stall_left = 0;
               hold_n = 0;
            end else begin
               chk("hold_result", result, held);
               chk("hold_in_ready", in_ready, 0);
            end
            if (stall_left > 0) begin
               out_ready = 0;
               stall_left--;
            end else begin
               out_ready = 1;
               pending = 0;
               chk_idle = 1;
            end
         end else begin
            out_ready = 0;
         end
      end
   end

   initial begin
      int bad;
      logic [3:0] ro;
      logic [63:0] ra, rb;
      rst_n = 0;
      in_valid = 0;
      a = 0;
      b = 0;
      op = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_err", err, 0);

      send(0, 5, 7);
      send(1, 9, 9);
      send(7, 64'h8000_0000_0000_0000, 4);
      send(8, '1, 1);
      send(9, '1, 1);

      hold_n = 10;
      send(10, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      bad = 0;
      repeat (64) begin
         @(negedge clk);
         if (in_ready) bad++;
      end
      chk("mul_busy_in_ready", bad, 0);
      send(0, 3, 4);

      send(11, 100, 7);
      send(12, 100, 7);
      send(11, 100, 0);
      send(12, 1234, 0);
      send(13, -64'sd7, 2);
      send(14, -64'sd7, 2);
      send(13, 64'h8000_0000_0000_0000, '1);
      send(14, 64'h8000_0000_0000_0000, '1);
      send(15, 3, 4);

      send(11, 1000, 3);
      repeat (19) @(posedge clk);
      #2 rst_n = 0;
      sb.delete();
      @(posedge clk);
      #2 rst_n = 1;
      #1;
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_in_ready", in_ready, 1);
      chk("rst2_zero", zero, 1);
      send(0, 1, 1);

      for (int i = 0; i < 120; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 9))
            0: rb = 0;
            1, 2: rb = 64'($urandom_range(1, 300));
            3: ra = 64'($urandom_range(0, 1000));
            default: ;
         endcase
         send(ro, ra, rb);
      end

      bad = 0;
      while ((sb.size() != 0 || pending) && bad < 2000) begin
         @(posedge clk);
         bad++;
      end
      chk("drain", sb.size(), 0);
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
